// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM main sequencer: state codes,
// instruction-class opcodes, datapath select values and the control word.
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   localparam logic [1:0] OP_DP    = 2'b00;
   localparam logic [1:0] OP_MEM   = 2'b01;
   localparam logic [1:0] OP_BR    = 2'b10;
   localparam logic [1:0] OP_UNDEF = 2'b11;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   // Moore part of the control word; Mealy strobes are qualified in the top.
   typedef struct packed {
      logic       mem_req;
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       alu_op;
      logic       reg_w;
      logic       branch;
   } ctrl_t;

endpackage

// File: rtl/arm_fsm_outdec.sv
// Combinational state -> Moore control-word decoder for the main sequencer.
module arm_fsm_outdec
   import arm_ctrl_pkg::*;
(
   input  state_t state_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      unique case (state_i)
         S_FETCH, S_DECODE: begin
            ctrl_o.alu_src_a  = 1'b1;
            ctrl_o.alu_src_b  = SRCB_FOUR;
            ctrl_o.result_src = RES_ALURES;
            ctrl_o.mem_req    = (state_i == S_FETCH);
         end
         S_MEMADR: ctrl_o.alu_src_b = SRCB_IMM;
         S_MEMRD, S_MEMWR: begin
            ctrl_o.adr_src = 1'b1;
            ctrl_o.mem_req = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.result_src = RES_RDATA;
            ctrl_o.reg_w      = 1'b1;
         end
         S_EXECR: ctrl_o.alu_op = 1'b1;
         S_EXECI: begin
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = 1'b1;
         end
         S_ALUWB: ctrl_o.reg_w = 1'b1;
         S_BRANCH: begin
            ctrl_o.alu_src_b  = SRCB_IMM;
            ctrl_o.result_src = RES_ALURES;
            ctrl_o.branch     = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/arm_main_fsm.sv
// Main sequencer of the multicycle ARM core: state register, next-state
// logic, Mealy strobe qualification and retired-instruction counter.
//
//  state  | meaning
//  FETCH  | read instruction at PC, PC+4 on mem_ready
//  DECODE | read registers, dispatch on Op
//  MEMADR | compute load/store address
//  MEMRD  | load data access, wait for mem_ready
//  MEMWB  | write loaded data to register file
//  MEMWR  | store data access, wait for mem_ready
//  EXECR  | ALU op with register operand
//  EXECI  | ALU op with immediate operand
//  ALUWB  | write ALU result to register file
//  BRANCH | compute branch target
module arm_main_fsm
   import arm_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       Op,
   input  logic [5:0]       Funct,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             IRWrite,
   output logic             NextPC,
   output logic             AdrSrc,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ResultSrc,
   output logic             ALUOp,
   output logic             RegW,
   output logic             MemW,
   output logic             Branch,
   output logic             undef_instr,
   output logic [CNT_W-1:0] retired,
   output logic [3:0]       state_dbg
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   ctrl_t            ctrl;
   logic             unused_funct;

   assign unused_funct = ^Funct[4:1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            unique case (Op)
               OP_MEM:  state_d = S_MEMADR;
               OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
               OP_BR:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_EXECR, S_EXECI: state_d = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
         default: state_d = S_FETCH;
      endcase
   end

   // An instruction retires on every return to FETCH, including undefined ones.
   always_comb begin
      retired_d = retired_q;
      if (state_q != S_FETCH && state_d == S_FETCH)
         retired_d = retired_q + CNT_W'(1);
   end

   arm_fsm_outdec u_outdec (
      .state_i (state_q),
      .ctrl_o  (ctrl)
   );

   // Strobes are gated by reset directly so none can fire while it is held.
   assign mem_req     = reset & ctrl.mem_req;
   assign IRWrite     = reset & (state_q == S_FETCH) & mem_ready;
   assign NextPC      = IRWrite;
   assign MemW        = reset & (state_q == S_MEMWR) & mem_ready;
   assign RegW        = reset & ctrl.reg_w;
   assign Branch      = reset & ctrl.branch;
   assign undef_instr = reset & (state_q == S_DECODE) & (Op == OP_UNDEF);
   assign AdrSrc      = ctrl.adr_src;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign ResultSrc   = ctrl.result_src;
   assign ALUOp       = ctrl.alu_op;
   assign retired     = retired_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_arm_main_fsm.sv
// Self-checking bench for arm_main_fsm: per-cycle expected state, control
// word and retired count are queued when stimulus is driven and compared.
module tb_arm_main_fsm;
   import arm_ctrl_pkg::*;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset, mem_ready;
   logic [1:0]    Op;
   logic [5:0]    Funct;
   logic          mem_req, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp;
   logic          RegW, MemW, Branch, undef_instr;
   logic [1:0]    ALUSrcB, ResultSrc;
   logic [CW-1:0] retired;
   logic [3:0]    state_dbg;
   logic [13:0]   ctl_obs;

   always #5 clk = ~clk;

   arm_main_fsm #(.CNT_W(CW)) dut (
      .clk (clk), .reset (reset), .Op (Op), .Funct (Funct),
      .mem_ready (mem_ready), .mem_req (mem_req), .IRWrite (IRWrite),
      .NextPC (NextPC), .AdrSrc (AdrSrc), .ALUSrcA (ALUSrcA),
      .ALUSrcB (ALUSrcB), .ResultSrc (ResultSrc), .ALUOp (ALUOp),
      .RegW (RegW), .MemW (MemW), .Branch (Branch),
      .undef_instr (undef_instr), .retired (retired), .state_dbg (state_dbg)
   );

   assign ctl_obs = {mem_req, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB,
                     ResultSrc, ALUOp, RegW, MemW, Branch, undef_instr};

   typedef struct packed {
      logic [3:0]    st;
      logic [13:0]   ctl;
      logic [CW-1:0] ret;
   } exp_t;

   exp_t          sb_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [CW-1:0] ret_m = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, got, want);
      end
   endtask

   function automatic logic [13:0] exp_ctl(state_t s, logic rdy, logic [1:0] op, logic rn);
      logic mreq, irw, npc, adr, sa, alop, rw, mw, br, und;
      logic [1:0] sb, rs;
      {mreq, irw, npc, adr, sa, alop, rw, mw, br, und} = '0;
      sb = 2'b00;
      rs = 2'b00;
      case (s)
         S_FETCH:  begin sa = 1; sb = 2'b10; rs = 2'b10; mreq = 1; irw = rdy; npc = rdy; end
         S_DECODE: begin sa = 1; sb = 2'b10; rs = 2'b10; und = (op == 2'b11); end
         S_MEMADR: sb = 2'b01;
         S_MEMRD:  begin adr = 1; mreq = 1; end
         S_MEMWB:  begin rs = 2'b01; rw = 1; end
         S_MEMWR:  begin adr = 1; mreq = 1; mw = rdy; end
         S_EXECR:  alop = 1;
         S_EXECI:  begin sb = 2'b01; alop = 1; end
         S_ALUWB:  rw = 1;
         S_BRANCH: begin sb = 2'b01; rs = 2'b10; br = 1; end
         default:  ;
      endcase
      if (!rn) {mreq, irw, npc, rw, mw, br, und} = '0;
      return {mreq, irw, npc, adr, sa, sb, rs, alop, rw, mw, br, und};
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic step(input logic rdy, input state_t s);
      exp_t e;
      mem_ready = rdy;
      sb_q.push_back('{st: s, ctl: exp_ctl(s, rdy, Op, reset), ret: ret_m});
      @(negedge clk);
      e = sb_q.pop_front();
      chk("state", 32'(state_dbg), 32'(e.st));
      chk("ctl",   32'(ctl_obs),   32'(e.ctl));
      chk("retired", 32'(retired), 32'(e.ret));
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                            input int fstall, input int stall);
      Op = op;
      Funct = funct;
      repeat (fstall) step(1'b0, S_FETCH);
      step(1'b1, S_FETCH);
      step(rnd(), S_DECODE);
      case (op)
         2'b01: begin
            step(rnd(), S_MEMADR);
            if (funct[0]) begin
               repeat (stall) step(1'b0, S_MEMRD);
               step(1'b1, S_MEMRD);
               step(rnd(), S_MEMWB);
            end else begin
               repeat (stall) step(1'b0, S_MEMWR);
               step(1'b1, S_MEMWR);
            end
         end
         2'b00: begin
            step(rnd(), funct[5] ? S_EXECI : S_EXECR);
            step(rnd(), S_ALUWB);
         end
         2'b10: step(rnd(), S_BRANCH);
         default: ;
      endcase
      ret_m = ret_m + 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      mem_ready = 1'b1;
      Op = 2'b01;
      Funct = 6'b011001;
      #1;
      step(1'b1, S_FETCH);
      step(1'b1, S_FETCH);
      reset = 1'b1;

      run_instr(2'b00, 6'b000100, 0, 0);
      run_instr(2'b01, 6'b011001, 0, 3);
      run_instr(2'b01, 6'b011000, 1, 2);
      run_instr(2'b11, 6'b000000, 0, 0);
      run_instr(2'b10, 6'b000000, 0, 0);
      run_instr(2'b00, 6'b100000, 2, 0);

      // reset asserted while a load waits in MEMRD
      Op = 2'b01;
      Funct = 6'b011001;
      step(1'b1, S_FETCH);
      step(1'b1, S_DECODE);
      step(1'b1, S_MEMADR);
      step(1'b0, S_MEMRD);
      reset = 1'b0;
      ret_m = '0;
      step(1'b1, S_FETCH);
      step(1'b1, S_FETCH);
      reset = 1'b1;

      // enough instructions to wrap the narrow counter
      for (int i = 0; i < 20; i++) begin
         logic [1:0] op;
         logic [5:0] fn;
         op = 2'($urandom_range(0, 3));
         fn = 6'($urandom);
         run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2));
      end
      step(1'b0, S_FETCH);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
